bram_load_store_unit: RTL
=========================

// Module: bram_load_store_unit
// PURPOSE
//  Upstream adapter between the core's load/store port and the 32-bit byte-masked block RAM.
//  Converts byte/half/word loads and stores at any byte address into BRAM word accesses.
//  Drives wr_mask and lane-shifted write data, and sign/zero-extends load data.
//  Splits an access that crosses a 4-byte word boundary into two BRAM accesses.
// PARAMETERS
//  ADDR_WIDTH     32  width of the byte address from the core
//  D_DEPTH_WIDTH  10  BRAM word-address width; must match the BRAM instance
// PORTS
//  clk           in   1              system clock, rising edge
//  rst           in   1              reset, asynchronous, active-high
//  req_valid     in   1              core presents a request
//  req_ready     out  1              unit accepts a request; high only in IDLE
//  req_we        in   1              1 = store, 0 = load
//  req_size      in   2              0 = byte, 1 = half, 2 = word, 3 = treated as word
//  req_unsigned  in   1              load zero-extends when 1, sign-extends when 0
//  req_addr      in   ADDR_WIDTH     byte address
//  req_wdata     in   32             store data, right-aligned
//  rsp_valid     out  1              one-cycle pulse: load data ready or store done
//  rsp_rdata     out  32             extended load data; 0 for stores
//  mem_en        out  1              BRAM enable
//  mem_wr_mask   out  4              BRAM byte write mask; 0 for loads
//  mem_addr      out  D_DEPTH_WIDTH  BRAM word address
//  mem_dataIn    out  32             BRAM write data, lane-aligned
//  mem_dataOut   in   32             BRAM read data, valid the cycle after mem_en
// BEHAVIOUR
//  BRAM model: 1-cycle registered read; write-first per masked byte.
//  Reset (async, rst=1): state=IDLE, rsp_valid=0, rsp_rdata=0, mem_en=0, mem_wr_mask=0.
//   All request registers cleared. req_ready=1 once rst deasserts.
//  Request latch: a request is accepted on a rising edge with req_valid && req_ready.
//   At that edge latch we, size, unsigned, off = addr[1:0], wa = addr[D_DEPTH_WIDTH+1:2].
//   Upper address bits are ignored.
//  Mask and data: base = 4'b0001 / 4'b0011 / 4'b1111 for byte / half / word.
//   m8 = base << off (8 bits). split = |m8[7:4].
//  FSM IDLE -> ACC1 -> [ACC2 if split] -> FIN -> IDLE. Every non-IDLE state lasts exactly 1 cycle.
//   IDLE: mem_en=0, req_ready=1.
//   ACC1: mem_en=1, mem_addr=wa, mem_wr_mask = we ? m8[3:0] : 0,
//    mem_dataIn = wdata << 8*off.
//   ACC2: mem_en=1, mem_addr = wa+1, wrapping modulo 2**D_DEPTH_WIDTH,
//    mem_wr_mask = we ? m8[7:4] : 0, mem_dataIn = wdata >> 8*(4-off).
//    lo_q <= mem_dataOut at the end of ACC2.
//   FIN: mem_en=0. Let hi = mem_dataOut and lo = split ? lo_q : mem_dataOut.
//    raw = ({hi,lo} >> 8*off)[31:0].
//    At the end of FIN: rsp_rdata <= we ? 0 : ext(raw), rsp_valid <= 1.
//  ext: byte -> raw[7:0] extended; half -> raw[15:0] extended; word -> raw.
//   The extension is signed or unsigned per the latched unsigned bit.
//  Latency, from accept edge to rsp_valid high: aligned = 2 cycles, split = 3 cycles.
//   A back-to-back request may be accepted in the same cycle that rsp_valid is high.
//  rsp_valid is high for exactly 1 cycle. rsp_rdata holds its value until the next response.
//  Outputs are driven only from state and latched registers. Inputs are not sampled outside the accept edge.
//  Reset during ACC2 or FIN: the ACC1 write of a split store may already be committed; it is not rolled back.
//   No rsp_valid is produced for the aborted request.
//  mem_wr_mask is never nonzero for a load, and never nonzero while mem_en=0.
// TESTING
//  1. Store word 0xDEADBEEF to 0x10, then load word 0x10
//     -> ACC1 mask 4'b1111, addr 4; rsp_rdata 0xDEADBEEF 2 cycles after accept.
//  2. Store byte 0x80 to 0x13; load byte signed and unsigned from 0x13
//     -> mask 4'b1000, dataIn[31:24]=0x80; rsp_rdata 0xFFFFFF80 / 0x00000080.
//  3. Store word 0x11223344 to 0x23 (split)
//     -> ACC1 addr 8, mask 4'b1000, dataIn 0x44000000;
//        ACC2 addr 9, mask 4'b0111, dataIn 0x00112233.
//     Load word 0x23 -> 0x11223344 after 3 cycles.
//  4. Half load at (2**D_DEPTH_WIDTH)*4-1 with unsigned=0
//     -> ACC2 mem_addr wraps to 0; result sign-extended from {word0[7:0], last[31:24]}.
//  5. req_valid held high for 3 aligned loads
//     -> accepts spaced 3 cycles apart; one rsp_valid pulse per request; no request lost.
//  6. Assert rst in ACC2 of a split load
//     -> mem_en=0 and rsp_valid=0 immediately; IDLE after release; next request completes normally.

Source files
------------

// File: rtl/bram_load_store_unit.sv
// Load/store adapter between the core's byte-addressed port and a 32-bit byte-masked BRAM.
// Accesses that straddle a word boundary are split into two consecutive BRAM accesses.
module bram_load_store_unit #(
  parameter int ADDR_WIDTH    = 32,
  parameter int D_DEPTH_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [1:0]               req_size,
  input  logic                     req_unsigned,
  input  logic [ADDR_WIDTH-1:0]    req_addr,
  input  logic [31:0]              req_wdata,
  output logic                     rsp_valid,
  output logic [31:0]              rsp_rdata,
  output logic                     mem_en,
  output logic [3:0]               mem_wr_mask,
  output logic [D_DEPTH_WIDTH-1:0] mem_addr,
  output logic [31:0]              mem_dataIn,
  input  logic [31:0]              mem_dataOut
);

  // state | meaning
  // IDLE  | ready for a request
  // ACC1  | BRAM access to the first (lower) word
  // ACC2  | BRAM access to the next word of a split access
  // FIN   | assemble and extend load data, issue response
  typedef enum logic [1:0] {IDLE, ACC1, ACC2, FIN} state_t;

  state_t                   state;
  logic                     we_q;
  logic [1:0]               size_q;
  logic                     uns_q;
  logic [1:0]               off_q;
  logic [D_DEPTH_WIDTH-1:0] wa_q;
  logic                     split_q;
  logic [3:0]               mask_hi_q;
  logic [31:0]              wdata_hi_q;
  logic [31:0]              lo_q;

  logic [3:0]  base_in;
  logic [7:0]  m8_in;
  logic [63:0] wide_in;
  logic [31:0] lo_word;
  logic [63:0] pair_sh;
  logic [31:0] raw;
  logic [31:0] ext_data;

  logic unused_addr_bits;
  assign unused_addr_bits = ^req_addr[ADDR_WIDTH-1:D_DEPTH_WIDTH+2];

  assign req_ready = (state == IDLE);

  always_comb begin
    base_in = 4'b1111;
    case (req_size)
      2'd0:    base_in = 4'b0001;
      2'd1:    base_in = 4'b0011;
      default: base_in = 4'b1111;
    endcase
    m8_in   = {4'b0000, base_in} << req_addr[1:0];
    wide_in = {32'b0, req_wdata} << {req_addr[1:0], 3'b000};
  end

  // Aligned loads read one word, so both halves of the pair come from the same data.
  always_comb begin
    lo_word  = split_q ? lo_q : mem_dataOut;
    pair_sh  = {mem_dataOut, lo_word} >> {off_q, 3'b000};
    raw      = pair_sh[31:0];
    ext_data = raw;
    case (size_q)
      2'd0:    ext_data = uns_q ? {24'b0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      2'd1:    ext_data = uns_q ? {16'b0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: ext_data = raw;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'd0;
      uns_q       <= 1'b0;
      off_q       <= 2'd0;
      wa_q        <= '0;
      split_q     <= 1'b0;
      mask_hi_q   <= 4'b0;
      wdata_hi_q  <= 32'b0;
      lo_q        <= 32'b0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 32'b0;
      mem_en      <= 1'b0;
      mem_wr_mask <= 4'b0;
      mem_addr    <= '0;
      mem_dataIn  <= 32'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q        <= req_we;
            size_q      <= req_size;
            uns_q       <= req_unsigned;
            off_q       <= req_addr[1:0];
            wa_q        <= req_addr[D_DEPTH_WIDTH+1:2];
            split_q     <= |m8_in[7:4];
            mask_hi_q   <= req_we ? m8_in[7:4] : 4'b0;
            wdata_hi_q  <= wide_in[63:32];
            mem_en      <= 1'b1;
            mem_addr    <= req_addr[D_DEPTH_WIDTH+1:2];
            mem_wr_mask <= req_we ? m8_in[3:0] : 4'b0;
            mem_dataIn  <= wide_in[31:0];
            state       <= ACC1;
          end
        end
        ACC1: begin
          if (split_q) begin
            mem_addr    <= wa_q + D_DEPTH_WIDTH'(1);
            mem_wr_mask <= mask_hi_q;
            mem_dataIn  <= wdata_hi_q;
            state       <= ACC2;
          end else begin
            mem_en      <= 1'b0;
            mem_wr_mask <= 4'b0;
            state       <= FIN;
          end
        end
        ACC2: begin
          lo_q        <= mem_dataOut;
          mem_en      <= 1'b0;
          mem_wr_mask <= 4'b0;
          state       <= FIN;
        end
        FIN: begin
          rsp_rdata <= we_q ? 32'b0 : ext_data;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
